// File: rtl/lsu_port_arbiter_if.sv
// Requester and sequencer-side signals of the LSU port arbiter.
// master = requesters + sequencer (drive requests/responses), slave = arbiter.
interface lsu_port_arbiter_if #(
   parameter int NUM_REQ = 2
);
   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   logic [NUM_REQ-1:0] req_valid_i;
   logic [NUM_REQ-1:0] req_is_store_i;
   logic [NUM_REQ-1:0] req_kill_i;
   logic [NUM_REQ-1:0] req_gnt_o;
   logic [NUM_REQ-1:0] req_done_o;
   logic [NUM_REQ-1:0] req_err_o;
   logic [IW-1:0]      owner_o;
   logic               busy_o;
   logic               mem_is_load_o;
   logic               mem_is_store_o;
   logic               mem_kill_o;
   logic               mem_ld_resp_valid_i;
   logic               mem_st_resp_gnt_i;

   modport master (
      output req_valid_i, req_is_store_i, req_kill_i,
      output mem_ld_resp_valid_i, mem_st_resp_gnt_i,
      input  req_gnt_o, req_done_o, req_err_o,
      input  owner_o, busy_o,
      input  mem_is_load_o, mem_is_store_o, mem_kill_o
   );

   modport slave (
      input  req_valid_i, req_is_store_i, req_kill_i,
      input  mem_ld_resp_valid_i, mem_st_resp_gnt_i,
      output req_gnt_o, req_done_o, req_err_o,
      output owner_o, busy_o,
      output mem_is_load_o, mem_is_store_o, mem_kill_o
   );
endinterface

// File: rtl/lsu_port_arbiter.sv
// Round-robin sharing of the TLB/dcache sequencer, one op outstanding.
// Optional BUSY watchdog abort enabled by defining LSU_ARB_TIMEOUT_EN.
module lsu_port_arbiter #(
   parameter int NUM_REQ        = 2,
   parameter int TIMEOUT_CYCLES = 64
) (
   input logic             clk,
   input logic             rst,
   lsu_port_arbiter_if.slave bus
);
   localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_BUSY,
      S_DRAIN
   } state_t;

   state_t             r_state;
   logic [IW-1:0]      r_rr;
   logic [IW-1:0]      r_owner;
   logic [NUM_REQ-1:0] r_gnt;
   logic [NUM_REQ-1:0] r_done;
   logic               r_store;
   logic               r_is_ld;
   logic               r_is_st;
   logic               r_kill;

   logic [NUM_REQ-1:0] w_elig;
   logic [IW:0]        w_sum;
   logic [IW-1:0]      w_win;
   logic               w_found;
   logic               w_cmpl;
   logic               w_okill;

`ifdef LSU_ARB_TIMEOUT_EN
   localparam int CW = $clog2(TIMEOUT_CYCLES);
   logic [CW-1:0]      r_cnt;
   logic [NUM_REQ-1:0] r_err;
`endif

   // Scan downward so the closest eligible index at/after rr wins last.
   always_comb begin
      w_elig  = bus.req_valid_i & ~bus.req_kill_i;
      w_found = 1'b0;
      w_win   = r_rr;
      w_sum   = '0;
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
         w_sum = {1'b0, r_rr} + (IW + 1)'(k);
         if (w_sum >= (IW + 1)'(NUM_REQ))
            w_sum = w_sum - (IW + 1)'(NUM_REQ);
         if (w_elig[w_sum[IW-1:0]]) begin
            w_found = 1'b1;
            w_win   = w_sum[IW-1:0];
         end
      end
   end

   assign w_cmpl  = r_store ? bus.mem_st_resp_gnt_i
                            : bus.mem_ld_resp_valid_i;
   assign w_okill = bus.req_kill_i[r_owner];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_rr    <= '0;
         r_owner <= '0;
         r_gnt   <= '0;
         r_done  <= '0;
         r_store <= 1'b0;
         r_is_ld <= 1'b0;
         r_is_st <= 1'b0;
         r_kill  <= 1'b0;
`ifdef LSU_ARB_TIMEOUT_EN
         r_cnt   <= '0;
         r_err   <= '0;
`endif
      end else begin
         r_gnt  <= '0;
         r_done <= '0;
         r_kill <= 1'b0;
`ifdef LSU_ARB_TIMEOUT_EN
         r_err  <= '0;
`endif
         unique case (r_state)
            S_IDLE: begin
               if (w_found) begin
                  r_gnt[w_win] <= 1'b1;
                  r_owner      <= w_win;
                  r_store      <= bus.req_is_store_i[w_win];
                  r_is_st      <= bus.req_is_store_i[w_win];
                  r_is_ld      <= ~bus.req_is_store_i[w_win];
                  if (w_win == IW'(NUM_REQ - 1))
                     r_rr <= '0;
                  else
                     r_rr <= w_win + 1'b1;
`ifdef LSU_ARB_TIMEOUT_EN
                  r_cnt        <= '0;
`endif
                  r_state      <= S_BUSY;
               end
            end
            S_BUSY: begin
               if (w_cmpl) begin
                  r_done[r_owner] <= 1'b1;
                  r_is_ld         <= 1'b0;
                  r_is_st         <= 1'b0;
                  r_state         <= S_DRAIN;
               end else if (w_okill) begin
                  r_kill  <= 1'b1;
                  r_is_ld <= 1'b0;
                  r_is_st <= 1'b0;
                  r_state <= S_DRAIN;
               end
`ifdef LSU_ARB_TIMEOUT_EN
               else if (r_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                  r_kill         <= 1'b1;
                  r_err[r_owner] <= 1'b1;
                  r_is_ld        <= 1'b0;
                  r_is_st        <= 1'b0;
                  r_state        <= S_DRAIN;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
`endif
            end
            S_DRAIN: r_state <= S_IDLE;
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.req_gnt_o      = r_gnt;
   assign bus.req_done_o     = r_done;
   assign bus.owner_o        = r_owner;
   assign bus.busy_o         = (r_state != S_IDLE);
   assign bus.mem_is_load_o  = r_is_ld;
   assign bus.mem_is_store_o = r_is_st;
   assign bus.mem_kill_o     = r_kill;
`ifdef LSU_ARB_TIMEOUT_EN
   assign bus.req_err_o      = r_err;
`else
   assign bus.req_err_o      = '0;
`endif
endmodule

// File: tb/tb_lsu_port_arbiter.sv
// Scoreboard bench for lsu_port_arbiter: directed ops push expected
// pulse snapshots, a negedge monitor pops and compares them.
module tb_lsu_port_arbiter;
   localparam int NR = 2;
   localparam int TO = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   lsu_port_arbiter_if #(.NUM_REQ(NR)) bus ();

   lsu_port_arbiter #(
      .NUM_REQ        (NR),
      .TIMEOUT_CYCLES (TO)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   typedef struct packed {
      logic [NR-1:0] gnt;
      logic [NR-1:0] done;
      logic [NR-1:0] err;
      logic          kill;
      logic          ld;
      logic          st;
      logic          owner;
   } snap_t;

   snap_t q[$];
   int    errs   = 0;
   int    checks = 0;
   bit    t2_on  = 1'b0;
   bit    saw_ld = 1'b0;

   function automatic snap_t ev(input logic [NR-1:0] g, input logic [NR-1:0] d,
                                input logic [NR-1:0] e, input logic k,
                                input logic l, input logic s, input logic o);
      snap_t r;
      r.gnt = g; r.done = d; r.err = e;
      r.kill = k; r.ld = l; r.st = s; r.owner = o;
      return r;
   endfunction

   task automatic chk(input string n, input logic [31:0] got, input logic [31:0] want);
      checks++;
      if (got !== want) begin
         errs++;
         $display("FAIL %s got=%0h want=%0h", n, got, want);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: every pulse cycle must match the next expected snapshot.
   always @(negedge clk) begin
      snap_t o;
      snap_t e;
      if (!rst && (((bus.req_gnt_o | bus.req_done_o | bus.req_err_o) != '0)
                   || bus.mem_kill_o)) begin
         o = ev(bus.req_gnt_o, bus.req_done_o, bus.req_err_o, bus.mem_kill_o,
                bus.mem_is_load_o, bus.mem_is_store_o, bus.owner_o);
         checks++;
         if (q.size() == 0) begin
            errs++;
            $display("FAIL pulse_unexpected got=%0h want=none", o);
         end else begin
            e = q.pop_front();
            if (o !== e) begin
               errs++;
               $display("FAIL pulse got=%0h want=%0h", o, e);
            end
         end
      end
      if (t2_on && bus.mem_is_load_o)
         saw_ld = 1'b1;
   end

   // Grant then complete after lat cycles; kv is applied during arbitration.
   task automatic op(input logic [NR-1:0] v, input logic [NR-1:0] s,
                     input logic w, input bit hold,
                     input logic [NR-1:0] kv, input int lat);
      logic [NR-1:0] g;
      logic          isst;
      g       = '0;
      g[w]    = 1'b1;
      isst    = s[w];
      bus.req_valid_i    = v;
      bus.req_is_store_i = s;
      bus.req_kill_i     = kv;
      q.push_back(ev(g, '0, '0, 1'b0, ~isst, isst, w));
      tick();
      bus.req_kill_i = '0;
      if (!hold)
         bus.req_valid_i = '0;
      for (int i = 1; i < lat; i++)
         tick();
      if (isst)
         bus.mem_st_resp_gnt_i = 1'b1;
      else
         bus.mem_ld_resp_valid_i = 1'b1;
      q.push_back(ev('0, g, '0, 1'b0, 1'b0, 1'b0, w));
      tick();
      bus.mem_st_resp_gnt_i   = 1'b0;
      bus.mem_ld_resp_valid_i = 1'b0;
      tick();
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      int  n;
      bit  ok;
      bus.req_valid_i         = '0;
      bus.req_is_store_i      = '0;
      bus.req_kill_i          = '0;
      bus.mem_ld_resp_valid_i = 1'b0;
      bus.mem_st_resp_gnt_i   = 1'b0;
      tick();
      tick();
      chk("rst_busy", 32'(bus.busy_o), 0);
      chk("rst_mem", 32'({bus.mem_is_load_o, bus.mem_is_store_o, bus.mem_kill_o}), 0);
      chk("rst_owner", 32'(bus.owner_o), 0);
      rst = 1'b0;

      // T1: single load, response 4 cycles after grant
      bus.req_valid_i = 2'b01;
      q.push_back(ev(2'b01, '0, '0, 1'b0, 1'b1, 1'b0, 1'b0));
      tick();
      bus.req_valid_i = '0;
      n = 0;
      for (int i = 0; i < 4; i++) begin
         n += int'(bus.mem_is_load_o);
         if (i < 3) tick();
      end
      bus.mem_ld_resp_valid_i = 1'b1;
      q.push_back(ev('0, 2'b01, '0, 1'b0, 1'b0, 1'b0, 1'b0));
      tick();
      bus.mem_ld_resp_valid_i = 1'b0;
      chk("t1_ld_cycles", 32'(n), 4);
      chk("t1_ld_low", 32'(bus.mem_is_load_o), 0);
      chk("t1_busy_drain", 32'(bus.busy_o), 1);
      tick();
      chk("t1_busy_idle", 32'(bus.busy_o), 0);

      // T2: both held, stores, grants alternate 0,1,0,1
      do_reset();
      saw_ld = 1'b0;
      t2_on  = 1'b1;
      for (int i = 0; i < 4; i++)
         op(2'b11, 2'b11, 1'(i % 2), 1'b1, 2'b00, 1);
      t2_on = 1'b0;
      bus.req_valid_i = '0;
      chk("t2_no_load", 32'(saw_ld), 0);

      // T3: owner 1, non-owner kill ignored, owner kill aborts
      bus.req_valid_i    = 2'b10;
      bus.req_is_store_i = 2'b00;
      q.push_back(ev(2'b10, '0, '0, 1'b0, 1'b1, 1'b0, 1'b1));
      tick();
      bus.req_valid_i = '0;
      bus.req_kill_i  = 2'b01;
      tick();
      chk("t3_nonowner_busy", 32'(bus.mem_is_load_o), 1);
      bus.req_kill_i = 2'b10;
      q.push_back(ev('0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b1));
      tick();
      bus.req_kill_i = '0;
      chk("t3_drain_busy", 32'(bus.busy_o), 1);
      chk("t3_mem_off", 32'({bus.mem_is_load_o, bus.mem_is_store_o}), 0);
      tick();
      chk("t3_idle", 32'(bus.busy_o), 0);

      // T3b: killed requester excluded from arbitration
      op(2'b11, 2'b00, 1'b1, 1'b0, 2'b01, 2);

      // T4: completion and owner kill together
      bus.req_valid_i = 2'b01;
      q.push_back(ev(2'b01, '0, '0, 1'b0, 1'b1, 1'b0, 1'b0));
      tick();
      bus.req_valid_i         = '0;
      bus.mem_ld_resp_valid_i = 1'b1;
      bus.req_kill_i          = 2'b01;
      q.push_back(ev('0, 2'b01, '0, 1'b0, 1'b0, 1'b0, 1'b0));
      tick();
      bus.mem_ld_resp_valid_i = 1'b0;
      bus.req_kill_i          = '0;
      chk("t4_no_kill", 32'(bus.mem_kill_o), 0);
      tick();

      // T4b: store ignores a load response
      bus.req_valid_i    = 2'b10;
      bus.req_is_store_i = 2'b10;
      q.push_back(ev(2'b10, '0, '0, 1'b0, 1'b0, 1'b1, 1'b1));
      tick();
      bus.req_valid_i         = '0;
      bus.mem_ld_resp_valid_i = 1'b1;
      tick();
      bus.mem_ld_resp_valid_i = 1'b0;
      chk("t4b_store_held", 32'(bus.mem_is_store_o), 1);
      bus.mem_st_resp_gnt_i = 1'b1;
      q.push_back(ev('0, 2'b10, '0, 1'b0, 1'b0, 1'b0, 1'b1));
      tick();
      bus.mem_st_resp_gnt_i = 1'b0;
      tick();

      // T5: no response
      bus.req_valid_i    = 2'b01;
      bus.req_is_store_i = 2'b00;
      q.push_back(ev(2'b01, '0, '0, 1'b0, 1'b1, 1'b0, 1'b0));
      tick();
      bus.req_valid_i = '0;
`ifdef LSU_ARB_TIMEOUT_EN
      q.push_back(ev('0, '0, 2'b01, 1'b1, 1'b0, 1'b0, 1'b0));
      ok = 1'b1;
      for (int i = 0; i < TO - 1; i++) begin
         tick();
         if (!bus.busy_o || bus.mem_kill_o) ok = 1'b0;
      end
      chk("t5_wait", 32'(ok), 1);
      tick();
      chk("t5_kill", 32'(bus.mem_kill_o), 1);
      chk("t5_err", 32'(bus.req_err_o), 32'h1);
      tick();
      tick();
      chk("t5_idle", 32'(bus.busy_o), 0);
`else
      ok = 1'b1;
      for (int i = 0; i < 100; i++) begin
         tick();
         if (!bus.busy_o || !bus.mem_is_load_o) ok = 1'b0;
      end
      chk("t5_hold", 32'(ok), 1);
      chk("t5_no_err", 32'(bus.req_err_o), 0);
      bus.req_kill_i = 2'b01;
      q.push_back(ev('0, '0, '0, 1'b1, 1'b0, 1'b0, 1'b0));
      tick();
      bus.req_kill_i = '0;
      tick();
`endif

      // T6: async reset mid-BUSY, then rr restarts at 0
      bus.req_valid_i = 2'b10;
      q.push_back(ev(2'b10, '0, '0, 1'b0, 1'b1, 1'b0, 1'b1));
      tick();
      bus.req_valid_i = '0;
      tick();
      chk("t6_pre_busy", 32'(bus.busy_o), 1);
      #2 rst = 1'b1;
      #1;
      chk("t6_async", 32'({bus.busy_o, bus.req_gnt_o, bus.req_done_o, bus.req_err_o,
                          bus.mem_kill_o, bus.mem_is_load_o, bus.mem_is_store_o,
                          bus.owner_o}), 0);
      tick();
      rst = 1'b0;
      op(2'b11, 2'b00, 1'b0, 1'b0, 2'b00, 2);

      tick();
      chk("queue_empty", 32'(q.size()), 0);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
